// File: rtl/regfile_scoreboard_if.sv
// rtl/regfile_scoreboard_if.sv - read/write/reserve bus between pipeline stages and the register file
interface regfile_scoreboard_if #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int ADDR_W   = $clog2(NUM_REGS)
);
    // Decode read ports
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_ready;

    // Writeback port
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;

    // Decode destination reservation
    logic                     rsv_en;
    logic [ADDR_W-1:0]        rsv_addr;
    logic                     rsv_accept;

    // Squash and scoreboard view for the hazard unit
    logic                     flush;
    logic [NUM_REGS-1:0]      pending_vec;

    // Pipeline side: decode, writeback and squash logic
    modport master (
        output rd_addr,
        input  rd_data,
        input  rd_ready,
        output wr_en,
        output wr_addr,
        output wr_data,
        output rsv_en,
        output rsv_addr,
        input  rsv_accept,
        output flush,
        input  pending_vec
    );

    // Register file side
    modport slave (
        input  rd_addr,
        output rd_data,
        output rd_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  rsv_en,
        input  rsv_addr,
        output rsv_accept,
        input  flush,
        output pending_vec
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - multi-read-port register file with pending-write scoreboard
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_scoreboard_if.slave  bus
);
    localparam int ADDR_W    = $clog2(NUM_REGS);
    localparam int ADDR_SPAN = 1 << ADDR_W;
    // One bit per encodable address: 1 where the address names a real register
    localparam logic [ADDR_SPAN-1:0] ADDR_OK =
        {ADDR_SPAN{1'b1}} >> (ADDR_SPAN - NUM_REGS);

    logic [DATA_W-1:0]    regs_q [NUM_REGS];
    logic [DATA_W-1:0]    regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]  pending_q;
    logic [NUM_REGS-1:0]  pending_d;

    // Pending bits widened to the full address space so stray addresses read as free
    logic [ADDR_SPAN-1:0] pend_ext;

    logic                 wr_take;
    logic                 rsv_zero;
    logic                 rsv_free;
    logic                 rsv_accept;
    logic                 rsv_take;

    // Widen pending vector; unused upper addresses are never pending
    always_comb begin
        pend_ext                 = '0;
        pend_ext[NUM_REGS-1:0]   = pending_q;
    end

    // Combinational read ports with optional same-cycle write forwarding
    always_comb begin
        bus.rd_data  = '0;
        bus.rd_ready = '1;
        for (int p = 0; p < NUM_RD; p++) begin
            logic [ADDR_W-1:0] a;
            logic [DATA_W-1:0] data;
            logic              rdy;
            a    = bus.rd_addr[p*ADDR_W +: ADDR_W];
            data = '0;
            rdy  = 1'b1;
            if (!ADDR_OK[a] || (ZERO_REG && (a == '0))) begin
                data = '0;
                rdy  = 1'b1;
            end else if (BYPASS && bus.wr_en && (bus.wr_addr == a)) begin
                data = bus.wr_data;
                rdy  = 1'b1;
            end else begin
                data = regs_q[a];
                rdy  = !pend_ext[a];
            end
            bus.rd_data[p*DATA_W +: DATA_W] = data;
            bus.rd_ready[p]                 = rdy;
        end
    end

    // Decide whether the writeback actually lands in the array this edge
    always_comb begin
        wr_take = bus.wr_en && ADDR_OK[bus.wr_addr] &&
                  !(ZERO_REG && (bus.wr_addr == '0));
    end

    // Reserve decode: a register being written this cycle can be re-reserved at once
    always_comb begin
        rsv_zero   = ZERO_REG && (bus.rsv_addr == '0);
        rsv_free   = !pend_ext[bus.rsv_addr] ||
                     (bus.wr_en && (bus.wr_addr == bus.rsv_addr));
        rsv_accept = bus.rsv_en && !reset && !bus.flush && (rsv_zero || rsv_free);
        rsv_take   = rsv_accept && ADDR_OK[bus.rsv_addr] && !rsv_zero;
    end

    // Next state: write clears pending first, then flush wipes or reserve sets
    always_comb begin
        regs_d    = regs_q;
        pending_d = pending_q;
        if (wr_take) begin
            regs_d[bus.wr_addr]    = bus.wr_data;
            pending_d[bus.wr_addr] = 1'b0;
        end
        if (bus.flush) begin
            pending_d = '0;
        end else if (rsv_take) begin
            pending_d[bus.rsv_addr] = 1'b1;
        end
    end

    // State registers; reset drops data and every reservation
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            pending_q <= '0;
        end else begin
            regs_q    <= regs_d;
            pending_q <= pending_d;
        end
    end

    assign bus.rsv_accept  = rsv_accept;
    assign bus.pending_vec = pending_q;
endmodule
